// File: rtl/i2s_mic_rx.sv
// I2S master receiver for two 18-bit MEMS mics on one SD line.
// Generates bclk/ws and emits each completed sample with a one-cycle data_rdy pulse.
module i2s_mic_rx #(
    parameter int BCLK_HALF = 16,
    parameter int DATA_BITS = 18,
    parameter int SLOT_BITS = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 sd,
    output logic                 bclk,
    output logic                 ws,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_ch,
    output logic                 data_rdy
);
    localparam int FRAME = 2 * SLOT_BITS;
    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int CNT_W = $clog2(FRAME);

    logic [DIV_W-1:0]     div_cnt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_nxt;
    logic [CNT_W-1:0]     pos;
    logic [1:0]           sync;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] word;
    logic                 frame_valid;
    logic                 tick;
    logic                 rise_evt;
    logic                 fall_evt;
    logic                 in_data;

    always_comb begin
        tick     = (div_cnt == DIV_W'(BCLK_HALF - 1));
        rise_evt = tick & ~bclk;
        fall_evt = tick & bclk;
        bit_nxt  = (bit_cnt == CNT_W'(FRAME - 1)) ? '0 : bit_cnt + CNT_W'(1);
        pos      = (bit_cnt >= CNT_W'(SLOT_BITS)) ? bit_cnt - CNT_W'(SLOT_BITS) : bit_cnt;
        in_data  = rise_evt && (pos >= CNT_W'(1)) && (pos <= CNT_W'(DATA_BITS));
        word     = {shift[DATA_BITS-2:0], sync[1]};
    end

    // sd is asynchronous to clock; sync[1] is the usable sample
    always_ff @(posedge clock) begin
        if (!reset) sync <= '0;
        else        sync <= {sync[0], sd};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bclk        <= 1'b0;
            ws          <= 1'b0;
            data        <= '0;
            data_ch     <= 1'b0;
            data_rdy    <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            frame_valid <= 1'b0;
        end else if (!enable) begin
            // data/data_ch keep the last good sample across a disable
            bclk        <= 1'b0;
            ws          <= 1'b0;
            data_rdy    <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            frame_valid <= 1'b0;
        end else begin
            data_rdy <= 1'b0;
            div_cnt  <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) bclk <= ~bclk;
            if (fall_evt) begin
                bit_cnt <= bit_nxt;
                ws      <= (bit_nxt >= CNT_W'(SLOT_BITS));
                if (bit_cnt == CNT_W'(FRAME - 1)) frame_valid <= 1'b1;
            end
            if (in_data) shift <= word;
            // The last data bit completes the word; publish it with the slot's channel
            if (rise_evt && pos == CNT_W'(DATA_BITS) && frame_valid) begin
                data     <= word;
                data_ch  <= ws;
                data_rdy <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_i2s_mic_rx.sv
// Directed bench for i2s_mic_rx with a simple I2S microphone model on sd.
// kc counts clock edges since the last reset/enable release; outputs are sampled on negedge.
module tb_i2s_mic_rx;
    localparam int BH = 4;
    localparam int DB = 18;
    localparam int SB = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          sd = 1'b1;
    logic          bclk, ws, data_ch, data_rdy;
    logic [DB-1:0] data;

    int checks = 0;
    int failures = 0;
    int kc = 0;

    logic [DB-1:0] word_l = 18'h2A5A5;
    logic [DB-1:0] word_r = 18'h15A5A;

    typedef struct {
        int            k;
        logic          ch;
        logic [DB-1:0] d;
    } pulse_t;
    pulse_t pq[$];

    i2s_mic_rx #(.BCLK_HALF(BH), .DATA_BITS(DB), .SLOT_BITS(SB)) dut (
        .clock(clock), .reset(reset), .enable(enable), .sd(sd),
        .bclk(bclk), .ws(ws), .data(data), .data_ch(data_ch), .data_rdy(data_rdy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) kc++;

    // Mic model: tracks slot position from ws edges, drives the next bit after each bclk fall
    logic          prev_bclk = 1'b0;
    logic          last_ws = 1'b0;
    int            pos_m = 0;
    logic [DB-1:0] mw;
    always @(negedge clock) begin
        if (prev_bclk === 1'b1 && bclk === 1'b0) begin
            if (ws !== last_ws) pos_m = 0;
            else                pos_m++;
            last_ws = ws;
            mw = ws ? word_r : word_l;
            if (pos_m >= 1 && pos_m <= DB) sd = mw[DB-pos_m];
            else                           sd = 1'b1;
        end
        prev_bclk = bclk;
        if (data_rdy === 1'b1) pq.push_back('{kc, data_ch, data});
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic run_to(input int k);
        while (kc < k) step();
    endtask

    task automatic release_run();
        @(negedge clock);
        reset = 1'b1;
        enable = 1'b1;
        kc = 0;
    endtask

    task automatic check_clocking(input string tag, input int n);
        int eb, ew;
        for (int k = 1; k <= n; k++) begin
            step();
            eb = (kc / BH) % 2;
            ew = (kc / (2 * BH * SB)) % 2;
            checks++;
            if (bclk !== eb[0]) begin
                failures++;
                if (failures < 20) $display("FAIL %s_bclk k=%0d got=%b exp=%0d", tag, kc, bclk, eb);
            end
            checks++;
            if (ws !== ew[0]) begin
                failures++;
                if (failures < 20) $display("FAIL %s_ws k=%0d got=%b exp=%0d", tag, kc, ws, ew);
            end
        end
    endtask

    task automatic check_pulses(input string tag, input int n, input int ek[4],
                                input logic ec[4], input logic [DB-1:0] ed[4]);
        checks++;
        if (pq.size() != n) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", tag, pq.size(), n);
        end
        for (int i = 0; i < n && i < pq.size(); i++) begin
            checks++;
            if (pq[i].k != ek[i] || pq[i].ch !== ec[i] || pq[i].d !== ed[i]) begin
                failures++;
                $display("FAIL %s_pulse%0d got k=%0d ch=%b d=%h exp k=%0d ch=%b d=%h",
                         tag, i, pq[i].k, pq[i].ch, pq[i].d, ek[i], ec[i], ed[i]);
            end
        end
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            checks++;
            if ({bclk, ws, data_ch, data_rdy, data} !== '0) begin
                failures++;
                $display("FAIL %s cyc=%0d got bclk=%b ws=%b ch=%b rdy=%b data=%h exp all 0",
                         tag, i, bclk, ws, data_ch, data_rdy, data);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b1;
        check_idle("reset_state", 5);
    endtask

    task automatic test_clocking();
        release_run();
        pq.delete();
        check_clocking("clk", 600);
        checks++;
        if (pq.size() != 0) begin
            failures++;
            $display("FAIL frame0_discard got=%0d pulses exp=0", pq.size());
        end
    endtask

    task automatic test_stream();
        run_to(900);
        word_l = 18'h20000;
        run_to(1440);
        check_pulses("stream", 4, '{660, 916, 1172, 1428}, '{1'b0, 1'b1, 1'b0, 1'b1},
                     '{18'h2A5A5, 18'h15A5A, 18'h20000, 18'h15A5A});
    endtask

    task automatic test_disable();
        word_l = 18'h2A5A5;
        run_to(1613);
        enable = 1'b0;
        pq.delete();
        step();
        checks++;
        if (bclk !== 1'b0 || ws !== 1'b0 || data_rdy !== 1'b0) begin
            failures++;
            $display("FAIL dis_idle got bclk=%b ws=%b rdy=%b exp 0 0 0", bclk, ws, data_rdy);
        end
        for (int i = 0; i < 39; i++) begin
            step();
            checks++;
            if (data !== 18'h15A5A || data_ch !== 1'b1 || data_rdy !== 1'b0 || bclk !== 1'b0) begin
                failures++;
                $display("FAIL dis_hold got data=%h ch=%b rdy=%b bclk=%b exp 15a5a 1 0 0",
                         data, data_ch, data_rdy, bclk);
            end
        end
        @(negedge clock);
        enable = 1'b1;
        kc = 0;
        run_to(1418);
        check_pulses("reenable", 3, '{660, 916, 1172, 0}, '{1'b0, 1'b1, 1'b0, 1'b0},
                     '{18'h2A5A5, 18'h15A5A, 18'h2A5A5, 18'h0});
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        pq.delete();
        check_idle("mid_reset", 12);
        checks++;
        if (pq.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_partial got=%0d pulses exp=0", pq.size());
        end
        release_run();
        check_clocking("recov", 40);
        run_to(920);
        check_pulses("recov", 2, '{660, 916, 0, 0}, '{1'b0, 1'b1, 1'b0, 1'b0},
                     '{18'h2A5A5, 18'h15A5A, 18'h0, 18'h0});
    endtask

    initial begin
        test_reset();
        test_clocking();
        test_stream();
        test_disable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
